// File: rtl/axi4l_cmd_master.sv
// axi4l_cmd_master: one-at-a-time command to AXI4-Lite transaction master
// Optional slave-handshake timeout enabled by defining AXI4L_CMD_TIMEOUT_EN.
module axi4l_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) $error("DATA_WIDTH must be 32 or 64");
  if (TIMEOUT_CYCLES < 2) $error("TIMEOUT_CYCLES must be at least 2");
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, rsp_rdata_n;
  logic [DATA_WIDTH/8-1:0] wstrb_n;
  logic [1:0] rsp_resp_n;
  logic cmd_ready_n, awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, rsp_valid_n, rsp_timeout_n;
  logic accept, abort;
  assign accept       = cmd_valid && cmd_ready;
  assign m_axi_awaddr = addr;
  assign m_axi_araddr = addr;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
`ifdef AXI4L_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt, cnt_n;
  logic busy, any_hs;
  assign busy   = state inside {WR, WR_RESP, RD_ADDR, RD_DATA};
  assign any_hs = (m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready) ||
                  (m_axi_bvalid && m_axi_bready) || (m_axi_arvalid && m_axi_arready) ||
                  (m_axi_rvalid && m_axi_rready);
  assign abort  = busy && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb cnt_n = accept ? '0 : !busy ? cnt : any_hs ? '0 : (&cnt) ? cnt : cnt + CW'(1);
  always_ff @(posedge clk) cnt <= rst ? '0 : cnt_n;
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_n       = state;
    addr_n        = addr;
    wdata_n       = m_axi_wdata;
    wstrb_n       = m_axi_wstrb;
    cmd_ready_n   = cmd_ready;
    awvalid_n     = m_axi_awvalid;
    wvalid_n      = m_axi_wvalid;
    bready_n      = m_axi_bready;
    arvalid_n     = m_axi_arvalid;
    rready_n      = m_axi_rready;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_resp_n    = rsp_resp;
    rsp_timeout_n = rsp_timeout;
    case (state)
      IDLE: if (accept) begin
        addr_n      = cmd_addr;
        wdata_n     = cmd_wdata;
        wstrb_n     = cmd_wstrb;
        cmd_ready_n = 1'b0;
        awvalid_n   = !cmd_rnw;
        wvalid_n    = !cmd_rnw;
        arvalid_n   = cmd_rnw;
        state_n     = cmd_rnw ? RD_ADDR : WR;
      end
      WR: begin
        awvalid_n = m_axi_awvalid && !m_axi_awready;
        wvalid_n  = m_axi_wvalid && !m_axi_wready;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: if (m_axi_bvalid) begin
        bready_n      = 1'b0;
        rsp_valid_n   = 1'b1;
        rsp_rdata_n   = '0;
        rsp_resp_n    = m_axi_bresp;
        rsp_timeout_n = 1'b0;
        state_n       = DONE;
      end
      RD_ADDR: if (m_axi_arready) begin
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
        state_n   = RD_DATA;
      end
      RD_DATA: if (m_axi_rvalid) begin
        rready_n      = 1'b0;
        rsp_valid_n   = 1'b1;
        rsp_rdata_n   = m_axi_rdata;
        rsp_resp_n    = m_axi_rresp;
        rsp_timeout_n = 1'b0;
        state_n       = DONE;
      end
      DONE: if (rsp_ready) begin
        rsp_valid_n = 1'b0;
        cmd_ready_n = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      bready_n      = 1'b0;
      arvalid_n     = 1'b0;
      rready_n      = 1'b0;
      rsp_valid_n   = 1'b1;
      rsp_rdata_n   = '0;
      rsp_resp_n    = 2'b10;
      rsp_timeout_n = 1'b1;
      state_n       = DONE;
    end
  end
  // IDLE leaves reset with cmd_ready low; it rises on the first edge after rst falls
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      cmd_ready     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_timeout   <= 1'b0;
    end else begin
      state         <= state_n;
      addr          <= addr_n;
      m_axi_wdata   <= wdata_n;
      m_axi_wstrb   <= wstrb_n;
      cmd_ready     <= (state_n == IDLE) ? 1'b1 : cmd_ready_n;
      m_axi_awvalid <= awvalid_n;
      m_axi_wvalid  <= wvalid_n;
      m_axi_bready  <= bready_n;
      m_axi_arvalid <= arvalid_n;
      m_axi_rready  <= rready_n;
      rsp_valid     <= rsp_valid_n;
      rsp_rdata     <= rsp_rdata_n;
      rsp_resp      <= rsp_resp_n;
      rsp_timeout   <= rsp_timeout_n;
    end
  end
endmodule

// File: tb/tb_axi4l_cmd_master.sv
// tb_axi4l_cmd_master: scoreboard bench with a behavioural AXI4-Lite slave
module tb_axi4l_cmd_master;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_rnw = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0] cmd_wstrb = 0;
  logic rsp_valid, rsp_ready = 1, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata = 0;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic arvalid, arready = 0, rvalid = 0, rready;
  logic [1:0] bresp = 0, rresp = 0;
  typedef struct {logic [31:0] rdata; logic [1:0] resp; logic to;} exp_t;
  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0;
  int aw_lat = 0, w_lat = 0, rb_lat = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0, bc = 0, rc = 0, b_hs = 0;
  logic [1:0] cfg_resp = 0;
  logic [31:0] cfg_rdata = 0, cur_addr = 0, cur_wdata = 0;
  logic [3:0] cur_wstrb = 0;
  logic got_aw = 0, got_w = 0, got_ar = 0, p_b = 0, p_r = 0;

  axi4l_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Slave: readies after a per-channel latency, B/R after a further latency
  initial forever begin
    @(posedge clk); #1;
    if (rst || cmd_ready) begin got_aw = 0; got_w = 0; got_ar = 0; bc = 0; rc = 0; end
    if (rst || p_b) bvalid = 0;
    if (rst || p_r) rvalid = 0;
    if (!awvalid) aw_cnt = 0;
    if (!wvalid) w_cnt = 0;
    if (!arvalid) ar_cnt = 0;
    awready = awvalid && aw_cnt == aw_lat;
    wready  = wvalid && w_cnt == w_lat;
    arready = arvalid && ar_cnt == aw_lat;
    if (awvalid) aw_cnt++;
    if (wvalid) w_cnt++;
    if (arvalid) ar_cnt++;
    if (got_aw && got_w && !bvalid) begin
      if (bc == rb_lat) begin bvalid = 1; bresp = cfg_resp; got_aw = 0; got_w = 0; bc = 0; end
      else bc++;
    end
    if (got_ar && !rvalid) begin
      if (rc == rb_lat) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_resp; got_ar = 0; rc = 0; end
      else rc++;
    end
    if (awvalid && awready) begin got_aw = 1; chk("awaddr", awaddr, cur_addr); chk("awprot", awprot, 0); end
    if (wvalid && wready) begin got_w = 1; chk("wdata", wdata, cur_wdata); chk("wstrb", wstrb, cur_wstrb); end
    if (arvalid && arready) begin got_ar = 1; chk("araddr", araddr, cur_addr); chk("arprot", arprot, 0); end
    p_b = bvalid && bready;
    p_r = rvalid && rready;
    if (p_b) b_hs++;
  end

  always @(negedge clk) begin
    #2;
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", rsp_resp, e.resp);
        chk("rsp_timeout", rsp_timeout, e.to);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
    if (!cmd_ready) chk("cmd_ready_wait", 0, 1);
  endtask

  task automatic send(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int la, input int lw, input int lrb, input logic [1:0] resp,
                      input logic [31:0] rd, input logic to);
    wait_idle();
    aw_lat = la; w_lat = lw; rb_lat = lrb; cfg_resp = resp; cfg_rdata = rd;
    cur_addr = a; cur_wdata = d; cur_wstrb = s;
    cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    q.push_back(to ? '{32'h0, 2'b10, 1'b1} : '{rnw ? rd : 32'h0, resp, 1'b0});
    @(negedge clk);
    cmd_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int na, nw, k, b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    // zero-wait write: aw/w at N+1, bready N+2, rsp N+3, cmd_ready N+4
    send(0, 32'h4, 32'h000000A5, 4'h1, 0, 0, 0, 2'b00, 0, 0);
    chk("zw_aw_w_valid", {awvalid, wvalid, cmd_ready}, 3'b110);
    @(negedge clk);
    chk("zw_bready", {bready, awvalid, wvalid}, 3'b100);
    @(negedge clk);
    chk("zw_rsp_valid", rsp_valid, 1);
    @(negedge clk);
    chk("zw_cmd_ready", cmd_ready, 1);
    // awready 3 cycles late, wready immediate
    b0 = b_hs;
    send(0, 32'h10, 32'h11223344, 4'hF, 3, 0, 0, 2'b00, 0, 0);
    na = 0; nw = 0; k = 0;
    while ((awvalid || wvalid) && k < 20) begin na += int'(awvalid); nw += int'(wvalid); @(negedge clk); k++; end
    chk("awvalid_cycles", na, 4);
    chk("wvalid_cycles", nw, 1);
    wait_idle();
    chk("single_b", b_hs - b0, 1);
    // W before AW
    send(0, 32'h14, 32'hCAFEF00D, 4'h6, 2, 0, 1, 2'b11, 0, 0);
    // read with two wait cycles
    send(1, 32'h8, 0, 0, 0, 0, 2, 2'b00, 32'hDEADBEEF, 0);
    chk("rd_arvalid", {arvalid, cmd_ready}, 2'b10);
    // SLVERR read held by rsp_ready low
    wait_idle();
    rsp_ready = 0;
    send(1, 32'hC, 0, 0, 1, 0, 0, 2'b10, 32'h12345678, 0);
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    repeat (5) begin
      chk("stall_payload", {rsp_valid, rsp_resp, rsp_timeout, cmd_ready, rsp_rdata}, {1'b1, 2'b10, 1'b0, 1'b0, 32'h12345678});
      @(negedge clk);
    end
    rsp_ready = 1;
    // random mix
    for (int i = 0; i < 8; i++) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      send(r, {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 4'($urandom_range(1, 15)),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1) != 0 ? 2'b11 : 2'b00, $urandom, 0);
    end
    // reset while awvalid is high
    send(0, 32'h20, 32'h5A5A5A5A, 4'h3, 1000, 0, 0, 2'b00, 0, 0);
    chk("pre_rst_awvalid", awvalid, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    q.delete();
    rst = 0;
    @(negedge clk);
    chk("after_rst_cmd_ready", cmd_ready, 1);
`ifdef AXI4L_CMD_TIMEOUT_EN
    // hung slave: response 16 cycles after awvalid rose
    send(0, 32'h30, 32'h1, 4'h1, 1000, 1000, 0, 2'b00, 0, 1);
    k = 0;
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    chk("timeout_latency", k, 16);
    chk("timeout_valids", {awvalid, wvalid}, 0);
`endif
    send(1, 32'h34, 0, 0, 0, 0, 0, 2'b00, 32'h0BADCAFE, 0);
    wait_idle();
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
